// File: rtl/switch_conditioner_pkg.sv
// Shared defaults and sizing helpers for the switch conditioner.
package switch_conditioner_pkg;

  localparam int unsigned WIDTH_DEFAULT        = 18;
  localparam int unsigned SAMPLE_DIV_DEFAULT   = 50000;
  localparam int unsigned STABLE_COUNT_DEFAULT = 10;

  // One spare bit so a terminal value of n-1 always fits, including n == 1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/switch_debounce_bit.sv
// One switch bit: two-flop synchroniser, tick-driven debounce counter,
// settled output and one-cycle change pulse.
module switch_debounce_bit
  import switch_conditioner_pkg::*;
#(
  parameter int unsigned STABLE_COUNT = STABLE_COUNT_DEFAULT,
  parameter logic        RESET_VALUE  = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sw_raw,
  input  logic tick,
  output logic sw_clean,
  output logic sw_changed
);

  localparam int unsigned    CW       = cnt_width(STABLE_COUNT);
  localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_COUNT - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= RESET_VALUE;
      sync2 <= RESET_VALUE;
    end else begin
      sync1 <= sw_raw;
      sync2 <= sync1;
    end
  end

  // Any agreement with the settled value discards progress, tick or not.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= '0;
      sw_clean   <= RESET_VALUE;
      sw_changed <= 1'b0;
    end else begin
      sw_changed <= 1'b0;
      if (sync2 == sw_clean) begin
        cnt <= '0;
      end else if (tick) begin
        if (cnt == CNT_LAST) begin
          sw_clean   <= sync2;
          cnt        <= '0;
          sw_changed <= 1'b1;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/switch_conditioner.sv
// Synchronise and debounce slide switches for the switch PIO in_port.
// Optional sticky edge capture with irq: SWITCH_CONDITIONER_EDGE_CAPTURE_EN.
module switch_conditioner
  import switch_conditioner_pkg::*;
#(
  parameter int unsigned      WIDTH        = WIDTH_DEFAULT,
  parameter int unsigned      SAMPLE_DIV   = SAMPLE_DIV_DEFAULT,
  parameter int unsigned      STABLE_COUNT = STABLE_COUNT_DEFAULT,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
`ifdef SWITCH_CONDITIONER_EDGE_CAPTURE_EN
  input  logic [WIDTH-1:0] edge_clear,
  output logic [WIDTH-1:0] edge_capture,
  output logic             irq,
`endif
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_changed,
  output logic             any_change,
  output logic             tick
);

  localparam int unsigned   PW       = cnt_width(SAMPLE_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(SAMPLE_DIV - 1);

  logic [PW-1:0] pre_cnt;

  // tick is registered on the wrap, giving a period of exactly SAMPLE_DIV.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt <= '0;
      tick    <= 1'b0;
    end else if (pre_cnt == PRE_LAST) begin
      pre_cnt <= '0;
      tick    <= 1'b1;
    end else begin
      pre_cnt <= pre_cnt + PW'(1);
      tick    <= 1'b0;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    switch_debounce_bit #(
      .STABLE_COUNT (STABLE_COUNT),
      .RESET_VALUE  (RESET_VALUE[i])
    ) u_bit (
      .clk        (clk),
      .reset_n    (reset_n),
      .sw_raw     (sw_raw[i]),
      .tick       (tick),
      .sw_clean   (sw_clean[i]),
      .sw_changed (sw_changed[i])
    );
  end

  assign any_change = |sw_changed;

`ifdef SWITCH_CONDITIONER_EDGE_CAPTURE_EN
  // Set wins over clear so a pulse coinciding with a clear is not lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_capture <= '0;
    end else begin
      edge_capture <= (edge_capture & ~edge_clear) | sw_changed;
    end
  end

  assign irq = |edge_capture;
`endif

endmodule

// File: tb/tb_switch_conditioner.sv
// Bench for switch_conditioner: per-cycle model comparison plus directed literal checks.
module tb_switch_conditioner;

  localparam int W  = 18;
  localparam int SD = 4;
  localparam int SC = 3;

  logic         clk     = 1'b0;
  logic         reset_n = 1'b1;
  logic [W-1:0] sw_raw  = '0;
  logic [W-1:0] sw_clean;
  logic [W-1:0] sw_changed;
  logic         any_change;
  logic         tick;
`ifdef SWITCH_CONDITIONER_EDGE_CAPTURE_EN
  logic [W-1:0] edge_clear = '0;
  logic [W-1:0] edge_capture;
  logic         irq;
`endif

  int total   = 0;
  int bad     = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  switch_conditioner #(
    .WIDTH        (W),
    .SAMPLE_DIV   (SD),
    .STABLE_COUNT (SC),
    .RESET_VALUE  (18'h0)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sw_raw       (sw_raw),
`ifdef SWITCH_CONDITIONER_EDGE_CAPTURE_EN
    .edge_clear   (edge_clear),
    .edge_capture (edge_capture),
    .irq          (irq),
`endif
    .sw_clean     (sw_clean),
    .sw_changed   (sw_changed),
    .any_change   (any_change),
    .tick         (tick)
  );

  // Model: raw passes through a 2-deep delay, ticks land on every SD-th edge,
  // and a bit flips once it has disagreed across SC consecutive ticks.
  logic [W-1:0] m_s1 = '0, m_s2 = '0, m_clean = '0, m_chg = '0, m_cap = '0, nxt_chg = '0;
  logic         m_tick = 1'b0;
  int           m_n = 0;
  int           m_seen [W];

  always begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      m_s1 = '0; m_s2 = '0; m_clean = '0; m_chg = '0; m_cap = '0;
      m_tick = 1'b0; m_n = 0;
      for (int i = 0; i < W; i++) m_seen[i] = 0;
    end else begin
`ifdef SWITCH_CONDITIONER_EDGE_CAPTURE_EN
      m_cap = (m_cap & ~edge_clear) | m_chg;
`endif
      nxt_chg = '0;
      for (int i = 0; i < W; i++) begin
        if (m_s2[i] == m_clean[i]) m_seen[i] = 0;
        else if (m_tick) begin
          m_seen[i] = m_seen[i] + 1;
          if (m_seen[i] == SC) begin
            m_clean[i] = ~m_clean[i];
            m_seen[i]  = 0;
            nxt_chg[i] = 1'b1;
          end
        end
      end
      m_chg  = nxt_chg;
      m_s2   = m_s1;
      m_s1   = sw_raw;
      m_n    = m_n + 1;
      m_tick = (m_n % SD) == 0;
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always begin
    @(negedge clk);
    if (started) begin
      chk("m_clean", sw_clean, m_clean);
      chk("m_changed", sw_changed, m_chg);
      chk("m_any", W'(any_change), W'(|m_chg));
      chk("m_tick", W'(tick), W'(m_tick));
`ifdef SWITCH_CONDITIONER_EDGE_CAPTURE_EN
      chk("m_cap", edge_capture, m_cap);
      chk("m_irq", W'(irq), W'(|m_cap));
`endif
    end
  end

  // Reset for one cycle; afterwards the next posedge is edge 1.
  task automatic do_reset();
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 chk("rst_clean", sw_clean, 18'h0);
    chk("rst_changed", sw_changed, 18'h0);
    @(negedge clk);
    #2 reset_n = 1'b1;
  endtask

  task automatic wait_edge(input int k);
    while (m_n < k) @(negedge clk);
  endtask

  int pulses, full, hi0;
  bit found;

  initial begin
    // Test 1: all ones from cycle 0, plus tick phase.
    sw_raw = 18'h3FFFF;
    do_reset();
    started = 1'b1;
    pulses = 0; full = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      chk("tick_lit", W'(tick), W'(k == 4 || k == 8 || k == 12 || k == 16 || k == 20));
      if (any_change) pulses++;
      if (sw_changed === 18'h3FFFF) full++;
      if (k == 11) chk("t1_clean_c11", sw_clean, 18'h0);
      if (k == 13) chk("t1_changed_c13", sw_changed, 18'h3FFFF);
      if (k == 15) chk("t1_clean_c15", sw_clean, 18'h3FFFF);
    end
    chk("t1_any_pulses", W'(pulses), 18'd1);
    chk("t1_full_pulses", W'(full), 18'd1);

    // Test 2: bouncing bit 0 is rejected, then a hold settles it.
    sw_raw = '0;
    do_reset();
    wait_edge(6);
    pulses = 0; hi0 = 0;
    for (int j = 0; j < 60; j++) begin
      sw_raw[0] = ((j / 5) % 2) == 0;
      @(negedge clk);
      if (sw_clean[0]) hi0++;
      if (sw_changed[0]) pulses++;
    end
    chk("t2_no_glitch", W'(hi0), 18'd0);
    sw_raw[0] = 1'b1;
    for (int h = 1; h <= 13; h++) begin
      @(negedge clk);
      if (sw_changed[0]) pulses++;
      if (h == 13) chk("t2_clean_hold", W'(sw_clean[0]), 18'd1);
    end
    chk("t2_one_pulse", W'(pulses), 18'd1);

    // Test 3: bits 5 and 9 together.
    sw_raw = 18'h221;
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      @(negedge clk);
      if (sw_changed != '0) begin
        found = 1'b1;
        chk("t3_changed", sw_changed, 18'h220);
        chk("t3_clean", sw_clean, 18'h221);
      end
    end
    chk("t3_seen", W'(found), 18'd1);
    repeat (5) @(negedge clk);
    chk("t3_hold", sw_clean, 18'h221);

    // Test 4: reset mid-debounce of bit 3 restarts the window.
    sw_raw = '0;
    do_reset();
    sw_raw = 18'h8;
    wait_edge(10);
    chk("t4_before", sw_clean, 18'h0);
    do_reset();
    pulses = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (any_change) pulses++;
      if (k == 11) chk("t4_clean_c11", sw_clean, 18'h0);
      if (k == 12) chk("t4_changed_c12", sw_changed, 18'h0);
      if (k == 15) chk("t4_clean_c15", sw_clean, 18'h8);
    end
    chk("t4_one_pulse", W'(pulses), 18'd1);

`ifdef SWITCH_CONDITIONER_EDGE_CAPTURE_EN
    // Test 5: clear coinciding with the pulse loses to the set.
    sw_raw = '0;
    do_reset();
    sw_raw = 18'h4;
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      @(negedge clk);
      if (sw_changed[2]) found = 1'b1;
    end
    chk("t5_seen", W'(found), 18'd1);
    edge_clear[2] = 1'b1;
    @(negedge clk);
    edge_clear = '0;
    chk("t5_cap_set", edge_capture, 18'h4);
    chk("t5_irq_set", W'(irq), 18'd1);
    repeat (2) @(negedge clk);
    edge_clear[2] = 1'b1;
    @(negedge clk);
    edge_clear = '0;
    chk("t5_cap_clr", edge_capture, 18'h0);
    chk("t5_irq_clr", W'(irq), 18'd0);
`endif

    @(negedge clk);
    started = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
